mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_pkg.sv | 25 ++
 rtl/mul_div_unit_if.sv | 30 +++
 rtl/mul_div_unit_counter.sv | 31 +++
 rtl/mul_div_unit.sv | 149 ++++++++++++++
 tb/tb_mul_div_unit.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// controller states and a small decode helper.
package mdu_pkg;

  // Operation select as presented by the decoder; reserved runs as a multiply
  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_UDIV = 2'b01,
    OP_UREM = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  // Controller states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // True for the two operations that run the restoring divider
  function automatic logic is_div(input op_e op);
    return (op == OP_UDIV) || (op == OP_UREM);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
// The master side issues operations, the slave side (the unit) returns results.
interface mul_div_unit_if
  import mdu_pkg::*;
#(
  parameter int N = 32
) ();

  logic         start;
  op_e          op;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [3:0]   Rd_in;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic [3:0]   Rd_out;
  logic         dz;

  modport master (
    output start, op, A, B, Rd_in,
    input  busy, done, result, Rd_out, dz
  );

  modport slave (
    input  start, op, A, B, Rd_in,
    output busy, done, result, Rd_out, dz
  );

endinterface

// File: rtl/mul_div_unit_counter.sv
// Iteration counter for the multiply/divide unit. Counts the shift/add or
// shift/subtract steps and flags the step that completes the operation.
module mdu_counter #(
  parameter int N = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] count;

  // Clear wins over enable so a newly accepted operation always starts at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply / unsigned divide unit. One N-bit adder/subtractor and
// one 2N-bit shift register (acc_hi:acc_lo) serve both operations:
//   MUL : acc_lo starts as the multiplier and shifts right LSB-first while the
//         partial product accumulates into acc_hi; low product ends in acc_lo.
//   DIV : acc_lo starts as the dividend and shifts left MSB-first into the
//         partial remainder acc_hi; quotient bits enter acc_lo from the right.
// A zero divisor never borrows, which naturally yields an all-ones quotient
// and a remainder equal to the dividend, so no special datapath case exists.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic          clk,
  input  logic          rst,
  mul_div_unit_if.slave bus
);

  state_e       state;
  op_e          op_q;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [3:0]   rd_q;
  logic [N-1:0] acc_hi;
  logic [N-1:0] acc_lo;

  logic         accept;
  logic         iterate;
  logic         last_iter;
  logic         div_mode;

  logic [N:0]   alu_a;
  logic [N:0]   alu_b;
  logic         alu_sub;
  logic [N+1:0] alu_res;
  logic [N-1:0] next_hi;
  logic [N-1:0] next_lo;
  logic [N-1:0] final_result;
  logic         final_dz;

  assign accept   = bus.start && ((state == S_IDLE) || (state == S_DONE));
  assign iterate  = (state == S_BUSY);
  assign div_mode = is_div(op_q);

  mdu_counter #(
    .N (N)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (iterate),
    .tc     (last_iter)
  );

  // One shared add/subtract step plus the shift that follows it
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sub = 1'b0;
    next_hi = acc_hi;
    next_lo = acc_lo;

    if (div_mode) begin
      alu_a   = {acc_hi, acc_lo[N-1]};
      alu_b   = {1'b0, op_b};
      alu_sub = 1'b1;
    end else begin
      alu_a   = {1'b0, acc_hi};
      alu_b   = acc_lo[0] ? {1'b0, op_a} : '0;
      alu_sub = 1'b0;
    end

    alu_res = alu_sub ? ({1'b0, alu_a} - {1'b0, alu_b})
                      : ({1'b0, alu_a} + {1'b0, alu_b});

    if (div_mode) begin
      if (!alu_res[N+1]) begin
        next_hi = alu_res[N-1:0];
        next_lo = {acc_lo[N-2:0], 1'b1};
      end else begin
        next_hi = alu_a[N-1:0];
        next_lo = {acc_lo[N-2:0], 1'b0};
      end
    end else begin
      next_hi = alu_res[N:1];
      next_lo = {alu_res[0], acc_lo[N-1:1]};
    end
  end

  // Pick the half of the shift register that holds the requested answer
  always_comb begin
    final_result = (op_q == OP_UREM) ? next_hi : next_lo;
    final_dz     = div_mode && (op_b == '0);
  end

  // Controller with registered status and result outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      op_q       <= OP_MUL;
      op_a       <= '0;
      op_b       <= '0;
      rd_q       <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.Rd_out <= '0;
      bus.dz     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            op_q     <= bus.op;
            op_a     <= bus.A;
            op_b     <= bus.B;
            rd_q     <= bus.Rd_in;
            acc_hi   <= '0;
            acc_lo   <= is_div(bus.op) ? bus.A : bus.B;
            bus.busy <= 1'b1;
            state    <= S_BUSY;
          end else begin
            state <= S_IDLE;
          end
        end
        S_BUSY: begin
          acc_hi <= next_hi;
          acc_lo <= next_lo;
          if (last_iter) begin
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            bus.result <= final_result;
            bus.Rd_out <= rd_q;
            bus.dz     <= final_dz;
            state      <= S_DONE;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed products, quotients and
// remainders, latency counting, ignored re-start, mid-operation reset and
// back-to-back issue with start held high.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int N = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks_total  = 0;
  int   checks_passed = 0;

  mul_div_unit_if #(.N(N)) bus ();

  mul_div_unit #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks_total++;
    if (observed === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Issue one operation, scramble the operand inputs after acceptance, then
  // measure latency and check the completed result. repulse_at > 0 raises
  // start (with A=9) again after that many busy edges.
  task automatic applyStimulus(input string tag, input op_e op,
                               input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic [3:0] rd, input logic [N-1:0] exp_result,
                               input logic exp_dz, input int repulse_at);
    int edges;
    int busy_cycles;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    bus.Rd_in = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = op_e'(2'($urandom_range(0, 3)));
    bus.A     = $urandom;
    bus.B     = $urandom;
    bus.Rd_in = 4'(~rd);
    checkOutput({tag, " busy after accept"}, 64'(bus.busy), 64'd1);
    edges       = 0;
    busy_cycles = 1;
    while (!bus.done && edges < 40) begin
      if (repulse_at > 0 && edges == repulse_at) begin
        bus.start = 1'b1;
        bus.A     = 9;
      end
      if (repulse_at > 0 && edges == repulse_at + 1) begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      edges++;
      if (bus.busy) busy_cycles++;
    end
    checkOutput({tag, " latency edges"}, 64'(edges), 64'(N));
    checkOutput({tag, " busy cycles"}, 64'(busy_cycles), 64'(N));
    checkOutput({tag, " done/busy"}, 64'({bus.done, bus.busy}), 64'd2);
    checkOutput({tag, " result"}, 64'(bus.result), 64'(exp_result));
    checkOutput({tag, " Rd_out"}, 64'(bus.Rd_out), 64'(rd));
    checkOutput({tag, " dz"}, 64'(bus.dz), 64'(exp_dz));
    @(posedge clk);
    #1;
    checkOutput({tag, " done single pulse"}, 64'(bus.done), 64'd0);
    checkOutput({tag, " result held"}, 64'(bus.result), 64'(exp_result));
  endtask

  // Reset in the middle of a divide must clear everything and never pulse done
  task automatic applyResetAbort();
    int done_seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_UDIV;
    bus.A     = 1000;
    bus.B     = 7;
    bus.Rd_in = 4'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("abort busy/done/dz", 64'({bus.busy, bus.done, bus.dz}), 64'd0);
    checkOutput("abort result", 64'(bus.result), 64'd0);
    checkOutput("abort Rd_out", 64'(bus.Rd_out), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) done_seen++;
    end
    checkOutput("abort no done", 64'(done_seen), 64'd0);
  endtask

  // Start held high: MUL 2*5 then UDIV 9/3, done pulses N+1 edges apart
  task automatic applyBackToBack();
    int edges;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.A     = 2;
    bus.B     = 5;
    bus.Rd_in = 4'd1;
    @(posedge clk);
    #1;
    bus.op    = OP_UDIV;
    bus.A     = 9;
    bus.B     = 3;
    bus.Rd_in = 4'd2;
    edges = 0;
    while (!bus.done && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput("b2b first latency", 64'(edges), 64'(N));
    checkOutput("b2b first result", 64'(bus.result), 64'd10);
    checkOutput("b2b first Rd_out", 64'(bus.Rd_out), 64'd1);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) checkOutput("b2b re-accept busy", 64'(bus.busy), 64'd1);
    end while (!bus.done && edges < 40);
    checkOutput("b2b done spacing", 64'(edges), 64'(N + 1));
    checkOutput("b2b second result", 64'(bus.result), 64'd3);
    checkOutput("b2b second Rd_out", 64'(bus.Rd_out), 64'd2);
    checkOutput("b2b second dz", 64'(bus.dz), 64'd0);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("b2b idle after", 64'({bus.busy, bus.done}), 64'd0);
  endtask

  // Main directed sequence
  initial begin
    bus.start = 1'b0;
    bus.op    = OP_MUL;
    bus.A     = '0;
    bus.B     = '0;
    bus.Rd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy/done/dz", 64'({bus.busy, bus.done, bus.dz}), 64'd0);
    checkOutput("reset result", 64'(bus.result), 64'd0);
    checkOutput("reset Rd_out", 64'(bus.Rd_out), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus("mul 7*6", OP_MUL, 32'd7, 32'd6, 4'd3, 32'd42, 1'b0, 0);
    applyStimulus("mul ff*ff", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 32'h0000_0001, 1'b0, 0);
    applyStimulus("mul wrap", OP_MUL, 32'h1234_5678, 32'h10, 4'd5, 32'h2345_6780, 1'b0, 0);
    applyStimulus("udiv 100/7", OP_UDIV, 32'd100, 32'd7, 4'd6, 32'd14, 1'b0, 0);
    applyStimulus("urem 100/7", OP_UREM, 32'd100, 32'd7, 4'd7, 32'd2, 1'b0, 0);
    applyStimulus("udiv big", OP_UDIV, 32'hFFFF_FFFF, 32'h10, 4'd8, 32'h0FFF_FFFF, 1'b0, 0);
    applyStimulus("urem big", OP_UREM, 32'hFFFF_FFFF, 32'h10, 4'd9, 32'h0000_000F, 1'b0, 0);
    applyStimulus("udiv small", OP_UDIV, 32'd3, 32'd7, 4'd10, 32'd0, 1'b0, 0);
    applyStimulus("udiv 5/0", OP_UDIV, 32'd5, 32'd0, 4'd11, 32'hFFFF_FFFF, 1'b1, 0);
    applyStimulus("urem 5/0", OP_UREM, 32'd5, 32'd0, 4'd12, 32'd5, 1'b1, 0);
    applyStimulus("rsvd 6*7", OP_RSVD, 32'd6, 32'd7, 4'd13, 32'd42, 1'b0, 0);
    applyStimulus("mul 3*4 repulse", OP_MUL, 32'd3, 32'd4, 4'd14, 32'd12, 1'b0, 10);
    applyResetAbort();
    applyStimulus("mul 2*3 after rst", OP_MUL, 32'd2, 32'd3, 4'd15, 32'd6, 1'b0, 0);
    applyBackToBack();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
